// File: rtl/mcu_spi_hub_pkg.sv
// Shared types and constants for the MCU SPI hub.
package mcu_spi_hub_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    SELECT,
    PAYLOAD,
    DISCARD
  } hub_state_t;

  localparam logic [7:0] HUB_SEL       = 8'hFF;
  localparam logic [7:0] DISCARD_REPLY = 8'h00;

endpackage

// File: rtl/mcu_spi_hub_if.sv
// Byte-target side of the hub: shared data byte, per-target strobes, replies and irqs.
interface mcu_spi_hub_if #(
  parameter int NUM_TARGETS = 4
);

  logic [7:0]                  tgt_din;
  logic [NUM_TARGETS-1:0]      tgt_strobe;
  logic [NUM_TARGETS-1:0]      tgt_start;
  logic [NUM_TARGETS-1:0][7:0] tgt_dout;
  logic [NUM_TARGETS-1:0]      tgt_irq;

  modport master (
    output tgt_din,
    output tgt_strobe,
    output tgt_start,
    input  tgt_dout,
    input  tgt_irq
  );

  modport slave (
    input  tgt_din,
    input  tgt_strobe,
    input  tgt_start,
    output tgt_dout,
    output tgt_irq
  );

endinterface

// File: rtl/mcu_spi_hub_pin_sync.sv
// Synchroniser for one asynchronous SPI pin with single-cycle rise/fall events.
module spi_pin_sync #(
  parameter int   DEPTH      = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [DEPTH-1:0] sync_reg;
  logic             prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= {DEPTH{IDLE_LEVEL}};
      prev_reg <= IDLE_LEVEL;
    end else begin
      sync_reg <= {sync_reg[DEPTH-2:0], pin};
      prev_reg <= sync_reg[DEPTH-1];
    end
  end

  assign level = sync_reg[DEPTH-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/mcu_spi_hub.sv
// SPI slave (mode 0, MSB first) that routes frame payload bytes to one of
// NUM_TARGETS byte targets chosen by the first byte, plus a hub irq-mask register.
module mcu_spi_hub
  import mcu_spi_hub_pkg::*;
#(
  parameter int NUM_TARGETS = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mcu_sclk,
  input  logic          mcu_csn,
  input  logic          mcu_mosi,
  output logic          mcu_miso,
  output logic          mcu_intn,
  mcu_spi_hub_if.master tgt
);

  localparam int IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

  logic sclk_level, sclk_rise, sclk_fall;
  logic csn_level, csn_rise, csn_fall;
  logic unused_edges;

  spi_pin_sync #(.DEPTH(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .pin(mcu_sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_pin_sync #(.DEPTH(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_csn_sync (
    .clk(clk), .reset(reset), .pin(mcu_csn),
    .level(csn_level), .rise(csn_rise), .fall(csn_fall)
  );

  // csn level already covers the rise event; sclk is only used through its edges
  assign unused_edges = sclk_level ^ csn_rise;

  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic                   mosi_bit;

  always_ff @(posedge clk) begin
    if (reset) mosi_sync_reg <= '0;
    else       mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mcu_mosi};
  end
  assign mosi_bit = mosi_sync_reg[SYNC_STAGES-1];

  hub_state_t             state_reg, state_next;
  logic [1:0]             flush_reg;
  logic                   flush_done;
  logic [2:0]             bit_cnt_reg;
  logic [6:0]             shift_reg;
  logic [7:0]             rx_byte;
  logic                   active, byte_done;
  logic [IDX_W-1:0]       sel_idx_reg;
  logic                   sel_hub_reg, first_reg, load_pending_reg;
  logic [7:0]             irq_mask_reg, reply_reg, din_reg, next_reply, pending_byte;
  logic [NUM_TARGETS-1:0] strobe_reg, start_reg, strobe_next, start_next, pending_vec;
  logic                   intn_reg;

  // After reset the csn synchroniser holds its idle value; only trust csn once refilled
  assign flush_done = (flush_reg == 2'(SYNC_STAGES));
  assign active     = state_reg inside {SELECT, PAYLOAD, DISCARD};
  assign rx_byte    = {shift_reg, mosi_bit};
  assign byte_done  = active && !csn_level && sclk_rise && (bit_cnt_reg == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= WAIT_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT_IDLE: if (flush_done && csn_level) state_next = IDLE;
      IDLE:      if (csn_fall) state_next = SELECT;
      SELECT: begin
        if (csn_level) begin
          state_next = IDLE;
        end else if (byte_done) begin
          if (rx_byte < 8'(NUM_TARGETS) || rx_byte == HUB_SEL) state_next = PAYLOAD;
          else                                                  state_next = DISCARD;
        end
      end
      PAYLOAD, DISCARD: if (csn_level) state_next = IDLE;
      default:   state_next = WAIT_IDLE;
    endcase
  end

  assign pending_vec  = tgt.tgt_irq & irq_mask_reg[NUM_TARGETS-1:0];
  assign pending_byte = 8'(pending_vec);
  assign next_reply   = (state_reg != PAYLOAD) ? DISCARD_REPLY :
                        sel_hub_reg            ? irq_mask_reg  : tgt.tgt_dout[sel_idx_reg];

  for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_strobe
    assign strobe_next[gi] = byte_done && (state_reg == PAYLOAD) && !sel_hub_reg &&
                             (sel_idx_reg == IDX_W'(gi));
    assign start_next[gi]  = strobe_next[gi] && first_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flush_reg        <= '0;
      bit_cnt_reg      <= '0;
      shift_reg        <= '0;
      sel_idx_reg      <= '0;
      sel_hub_reg      <= 1'b0;
      first_reg        <= 1'b0;
      load_pending_reg <= 1'b0;
      irq_mask_reg     <= 8'hFF;
      reply_reg        <= '0;
      din_reg          <= '0;
      strobe_reg       <= '0;
      start_reg        <= '0;
      intn_reg         <= 1'b1;
    end else begin
      if (!flush_done) flush_reg <= flush_reg + 2'd1;
      intn_reg   <= ~|pending_vec;
      strobe_reg <= strobe_next;
      start_reg  <= start_next;

      // A deasserted csn aborts any partial byte, even one completing this cycle
      if (!active || csn_level) begin
        bit_cnt_reg      <= '0;
        load_pending_reg <= 1'b0;
      end else if (sclk_rise) begin
        shift_reg   <= rx_byte[6:0];
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
      end

      if (byte_done) begin
        load_pending_reg <= 1'b1;
        if (state_reg == SELECT) begin
          sel_hub_reg <= (rx_byte == HUB_SEL);
          sel_idx_reg <= rx_byte[IDX_W-1:0];
          first_reg   <= 1'b1;
        end else if (state_reg == PAYLOAD) begin
          first_reg <= 1'b0;
          if (sel_hub_reg && first_reg) irq_mask_reg <= rx_byte;
          if (!sel_hub_reg)             din_reg      <= rx_byte;
        end
      end

      if (state_reg == IDLE && csn_fall) begin
        reply_reg <= pending_byte;
      end else if (active && !csn_level && sclk_fall) begin
        if (load_pending_reg) begin
          reply_reg        <= next_reply;
          load_pending_reg <= 1'b0;
        end else begin
          reply_reg <= {reply_reg[6:0], 1'b0};
        end
      end
    end
  end

  assign mcu_miso       = reply_reg[7];
  assign mcu_intn       = intn_reg;
  assign tgt.tgt_din    = din_reg;
  assign tgt.tgt_strobe = strobe_reg;
  assign tgt.tgt_start  = start_reg;

endmodule

// File: tb/tb_mcu_spi_hub.sv
// Bench for mcu_spi_hub: drives SPI frames as the MCU and scoreboards target strobes and MISO bytes.
module tb_mcu_spi_hub;

  localparam int NT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sclk = 1'b0;
  logic csn = 1'b1;
  logic mosi = 1'b0;
  logic miso, intn;
  logic [7:0] t2_reg;

  int checks = 0;
  int errors = 0;
  logic [15:0] strb_q[$];
  logic [15:0] mon_exp;

  mcu_spi_hub_if #(.NUM_TARGETS(NT)) tgt_if ();

  mcu_spi_hub #(.NUM_TARGETS(NT), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .mcu_sclk(sclk), .mcu_csn(csn), .mcu_mosi(mosi),
    .mcu_miso(miso), .mcu_intn(intn), .tgt(tgt_if)
  );

  always #5 clk = ~clk;

  // Target 2 answers with the complement of the last byte it received
  always @(posedge clk) begin
    if (reset)                       t2_reg <= 8'h5A;
    else if (tgt_if.tgt_strobe[2])   t2_reg <= tgt_if.tgt_din ^ 8'hFF;
  end

  always_comb begin
    tgt_if.tgt_dout[0] = 8'hC0;
    tgt_if.tgt_dout[1] = 8'hC1;
    tgt_if.tgt_dout[2] = t2_reg;
    tgt_if.tgt_dout[3] = 8'hC3;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_strb(input int idx, input logic [7:0] din, input bit start);
    logic [3:0] v;
    v = 4'(1 << idx);
    strb_q.push_back({v, start ? v : 4'h0, din});
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      clks(6);
      rx[i] = miso;
      sclk = 1'b1;
      clks(6);
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input int nb, input logic [7:0] b0, b1, b2,
                           input logic [7:0] e0, e1, e2);
    logic [7:0] tx[3];
    logic [7:0] ex[3];
    logic [7:0] rx;
    tx[0] = b0; tx[1] = b1; tx[2] = b2;
    ex[0] = e0; ex[1] = e1; ex[2] = e2;
    csn = 1'b0;
    clks(8);
    for (int k = 0; k < nb; k++) begin
      spi_bits(tx[k], 8, rx);
      check($sformatf("miso sel%0h byte%0d", b0, k), rx, ex[k]);
      $display("frame sel %0h byte %0d tx %0h rx %0h", b0, k, tx[k], rx);
    end
    clks(6);
    csn = 1'b1;
    clks(12);
  endtask

  // Every strobe/start cycle must match the next scoreboard entry
  always @(negedge clk) begin
    if (tgt_if.tgt_strobe != '0 || tgt_if.tgt_start != '0) begin
      if (strb_q.size() == 0) begin
        check("strobe_unexpected", {tgt_if.tgt_strobe, tgt_if.tgt_start, tgt_if.tgt_din}, 0);
      end else begin
        mon_exp = strb_q.pop_front();
        check("strobe", tgt_if.tgt_strobe, mon_exp[15:12]);
        check("start",  tgt_if.tgt_start,  mon_exp[11:8]);
        check("din",    tgt_if.tgt_din,    mon_exp[7:0]);
      end
    end
  end

  initial begin
    logic [7:0] rx;
    tgt_if.tgt_irq = '0;
    reset = 1'b1;
    clks(4);
    check("rst_miso",   miso, 1'b0);
    check("rst_intn",   intn, 1'b1);
    check("rst_strobe", tgt_if.tgt_strobe, 4'h0);
    check("rst_start",  tgt_if.tgt_start, 4'h0);
    check("rst_din",    tgt_if.tgt_din, 8'h00);
    reset = 1'b0;
    clks(6);

    // Two payload bytes to target 1
    exp_strb(1, 8'hA5, 1'b1);
    exp_strb(1, 8'h3C, 1'b0);
    run_frame(3, 8'h01, 8'hA5, 8'h3C, 8'h00, 8'hC1, 8'hC1);
    check("din_last", tgt_if.tgt_din, 8'h3C);

    // Target 2 reply refreshes after each strobe
    exp_strb(2, 8'h00, 1'b1);
    exp_strb(2, 8'h00, 1'b0);
    run_frame(3, 8'h02, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hFF);

    // Interrupt path and hub mask register
    tgt_if.tgt_irq = 4'b0100;
    clks(1);
    check("intn_irq", intn, 1'b0);
    run_frame(2, 8'hFF, 8'h00, 8'h00, 8'h04, 8'hFF, 8'h00);
    check("intn_masked", intn, 1'b1);
    run_frame(3, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF);
    check("intn_unmasked", intn, 1'b0);
    tgt_if.tgt_irq = 4'b0000;
    clks(1);
    check("intn_clear", intn, 1'b1);

    // Out-of-range selector is discarded
    run_frame(3, 8'h07, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00);

    // csn raised after 5 bits of a payload byte
    csn = 1'b0;
    clks(8);
    spi_bits(8'h00, 8, rx);
    check("abort_sel_miso", rx, 8'h00);
    spi_bits(8'hF0, 5, rx);
    clks(6);
    csn = 1'b1;
    clks(12);
    exp_strb(0, 8'h11, 1'b1);
    run_frame(2, 8'h00, 8'h11, 8'h00, 8'h00, 8'hC0, 8'h00);

    // Reset in the middle of a frame
    exp_strb(1, 8'hAA, 1'b1);
    csn = 1'b0;
    clks(8);
    spi_bits(8'h01, 8, rx);
    check("prerst_miso0", rx, 8'h00);
    spi_bits(8'hAA, 8, rx);
    check("prerst_miso1", rx, 8'hC1);
    reset = 1'b1;
    clks(2);
    reset = 1'b0;
    check("rst_mid_din", tgt_if.tgt_din, 8'h00);
    clks(4);
    spi_bits(8'h55, 8, rx);
    spi_bits(8'h66, 8, rx);
    spi_bits(8'h77, 8, rx);
    clks(6);
    csn = 1'b1;
    clks(12);
    exp_strb(1, 8'h99, 1'b1);
    run_frame(2, 8'h01, 8'h99, 8'h00, 8'h00, 8'hC1, 8'h00);

    clks(10);
    check("strb_q_empty", strb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
